// File: rtl/sauria_pkg.sv
// Shared encodings for the SAURIA configuration sequencer: command ops,
// FSM states and AXI response codes.
package sauria_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_POLL     = 2'b01,
    OP_WAIT_IRQ = 2'b10,
    OP_RSVD     = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_IRQ_WAIT,
    ST_ERR
  } seq_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         CNT_W           = 16;

endpackage

// File: rtl/sauria_cfg_sequencer.sv
// Command sequencer issuing AXI4-Lite config writes, bit-mask polls and IRQ
// waits towards the SAURIA subsystem; any failure parks it in a sticky ERR.
module sauria_cfg_sequencer
  import sauria_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_system_clk,
  input  logic        i_system_rstn,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  input  logic        i_irq,
  output logic [31:0] o_awaddr,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  seq_state_e       state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             bready_q, bready_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      araddr_q, araddr_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = 1'b0;
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          data_d = i_cmd_data;
          cnt_d  = '0;
          case (cmd_op_e'(i_cmd_op))
            OP_WRITE: begin
              state_d   = ST_WR_REQ;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              awaddr_d  = i_cmd_addr;
              wdata_d   = i_cmd_data;
              wstrb_d   = 4'hF;
            end
            OP_POLL: begin
              state_d   = ST_RD_REQ;
              arvalid_d = 1'b1;
              araddr_d  = i_cmd_addr;
            end
            OP_WAIT_IRQ: state_d = ST_IRQ_WAIT;
            default:     state_d = ST_ERR;
          endcase
        end
      end

      // AW and W complete independently; B is only accepted once both are done.
      ST_WR_REQ: begin
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end

      ST_WR_RESP: begin
        bready_d = 1'b1;
        if (i_bvalid) begin
          bready_d = 1'b0;
          state_d  = (i_bresp == AXI_RESP_OKAY) ? ST_IDLE : ST_ERR;
        end
      end

      ST_RD_REQ: begin
        arvalid_d = 1'b1;
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        rready_d = 1'b1;
        if (i_rvalid) begin
          rready_d = 1'b0;
          if (i_rresp != AXI_RESP_OKAY) begin
            state_d = ST_ERR;
          end else if ((i_rdata & data_q) == data_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == TIMEOUT_CNT) begin
              state_d = ST_ERR;
            end else begin
              state_d   = ST_RD_REQ;
              arvalid_d = 1'b1;
            end
          end
        end
      end

      ST_IRQ_WAIT: begin
        if (i_irq) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TIMEOUT_CNT) state_d = ST_ERR;
        end
      end

      default: begin
        state_d   = ST_ERR;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase

    // Status outputs are derived from the next state so they stay registered.
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_ERR);
    err_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge i_system_clk) begin
    if (!i_system_rstn) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      araddr_q    <= araddr_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_awaddr    = awaddr_q;
  assign o_awvalid   = awvalid_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_wvalid    = wvalid_q;
  assign o_bready    = bready_q;
  assign o_araddr    = araddr_q;
  assign o_arvalid   = arvalid_q;
  assign o_rready    = rready_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: doc/sauria_cfg_sequencer.md
SAURIA_CFG_SEQUENCER -- requirements
Module: sauria_cfg_sequencer
Upstream command sequencer that drives the SAURIA subsystem AXI4-Lite configuration slave and waits on its interrupts.

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning max poll reads or IRQ wait cycles before error (1..65535).
REQ-002 SHALL have port i_system_clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port i_system_rstn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_cmd_valid  in  1  command offered.
REQ-005 SHALL have port o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
REQ-006 SHALL have port i_cmd_op  in  2  00 WRITE, 01 POLL, 10 WAIT_IRQ, 11 reserved.
REQ-007 SHALL have port i_cmd_addr  in  32  config register address.
REQ-008 SHALL have port i_cmd_data  in  32  write data (WRITE) or required bit mask (POLL).
REQ-009 SHALL have port i_irq  in  1  level interrupt from subsystem (ctrl/DMA/SAURIA OR'ed externally).
REQ-010 SHALL have ports o_awaddr out 32, o_awvalid out 1, i_awready in 1: AXI4-Lite write address channel.
REQ-011 SHALL have ports o_wdata out 32, o_wstrb out 4, o_wvalid out 1, i_wready in 1: write data channel.
REQ-012 SHALL have ports i_bresp in 2, i_bvalid in 1, o_bready out 1: write response channel.
REQ-013 SHALL have ports o_araddr out 32, o_arvalid out 1, i_arready in 1: read address channel.
REQ-014 SHALL have ports i_rdata in 32, i_rresp in 2, i_rvalid in 1, o_rready out 1: read data channel.
REQ-015 SHALL have port o_busy  out  1  high when a command is in progress.
REQ-016 SHALL have port o_err  out  1  sticky error flag.

Function
REQ-017 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, IRQ_WAIT, ERR; all outputs registered.
REQ-018 SHALL assert o_cmd_ready only in IDLE; accept on valid&ready, latching op/addr/data; clear 16-bit counter.
REQ-019 WRITE: next cycle o_awvalid=o_wvalid=1, o_awaddr=addr, o_wdata=data, o_wstrb=4'hF; each valid drops independently after its own handshake; leave WR_REQ when both done.
REQ-020 WR_RESP: o_bready=1; on i_bvalid, bresp==OKAY -> IDLE, else -> ERR.
REQ-021 POLL: RD_REQ holds o_arvalid, o_araddr=addr until i_arready; RD_RESP holds o_rready=1 until i_rvalid.
REQ-022 On read data: rresp!=OKAY -> ERR; (rdata & data)==data -> IDLE; else counter+1, counter==TIMEOUT -> ERR, otherwise re-issue AR next cycle.
REQ-023 WAIT_IRQ: IRQ_WAIT exits to IDLE on first cycle i_irq=1 (incl. the cycle after accept); counter increments each cycle without irq; reaching TIMEOUT -> ERR.
REQ-024 Reserved op 11 SHALL go to ERR on the cycle after acceptance, with no AXI activity.
REQ-025 ERR is terminal: o_err=1, o_cmd_ready=0, all valids low, o_bready=o_rready=0; exit only by reset.
REQ-026 o_busy=1 in every state except IDLE and ERR; back-to-back commands: minimum one IDLE cycle between commands.

Reset
REQ-027 On i_system_rstn=0 at a clock edge, SHALL enter IDLE next cycle with every valid/ready output, o_busy, o_err, counter and address/data outputs at 0, except o_cmd_ready which SHALL be 0 during reset and 1 thereafter.
REQ-028 Reset mid-transaction SHALL abandon it; the subsystem shares this reset so no outstanding response is expected afterward.

Structure
REQ-029 Op encodings, state enum and AXI resp OKAY constant SHALL live in sauria_pkg; no sub-module required, one FSM plus counter.

Verification
REQ-030 WRITE addr 0x0000_0010 data 0xDEAD_BEEF, awready/wready same cycle, bvalid OKAY 2 cycles later -> one AW/W beat, wstrb 0xF, back in IDLE, o_err=0.
REQ-031 WRITE with wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, single B accepted.
REQ-032 POLL addr 0x20 mask 0x1, rdata 0x0,0x0,0x1 -> exactly three AR beats, IDLE after third R, counter=2.
REQ-033 POLL with TIMEOUT=4, rdata always 0 -> four reads then ERR, o_err=1, o_cmd_ready=0 until reset.
REQ-034 WAIT_IRQ, i_irq rising after 10 cycles -> IDLE next cycle; WRITE with bresp=SLVERR -> ERR.
REQ-035 Reset asserted while in RD_RESP -> next cycle all outputs 0, o_cmd_ready=1 after release.
